// File: rtl/fact_engine.sv
// Iterative factorial engine behind a 4-register memory-mapped port.
// Read data is registered and qualified by rd_en, which gates the downstream tri-state buffer.
module fact_engine #(
  parameter int DW    = 32,
  parameter int NW    = 4,
  parameter int N_MAX = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    addr,
  input  logic          we,
  input  logic          re,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd_data,
  output logic          rd_en,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE, ERR} state_t;

  state_t        state, state_nx;
  logic [NW-1:0] n_reg, cnt;
  logic [DW-1:0] prod, rd_mux;
  logic          busy, go, too_big;

  assign busy    = (state == CALC);
  assign go      = we && (addr == 2'd1) && wd[0] && !busy;
  assign too_big = (n_reg > NW'(N_MAX));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (go) state_nx = too_big ? ERR : CALC;
      CALC:            if (cnt <= NW'(1)) state_nx = DONE;
      default:         state_nx = IDLE;
    endcase
  end

  // Read mux sees pre-write register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0: rd_mux = DW'(n_reg);
      2'd2: rd_mux = DW'({busy, err, done});
      2'd3: rd_mux = prod;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg   <= '0;
      cnt     <= '0;
      prod    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
      rd_en   <= 1'b0;
    end else begin
      if (we && addr == 2'd0) n_reg <= wd[NW-1:0];
      // N is latched into cnt only on an accepted GO, so later N writes never disturb a run.
      if (go) begin
        done <= 1'b0;
        if (too_big) begin
          err  <= 1'b1;
          prod <= '0;
        end else begin
          err  <= 1'b0;
          cnt  <= n_reg;
          prod <= DW'(1);
        end
      end else if (busy) begin
        if (cnt > NW'(1)) begin
          prod <= prod * DW'(cnt);
          cnt  <= cnt - NW'(1);
        end else begin
          done <= 1'b1;
        end
      end
      rd_en <= re;
      if (re) rd_data <= rd_mux;
    end
  end

endmodule
